transpose_buf: RTL



---
 rtl/transpose_pkg.sv | 21 ++
 rtl/tbuf_bank.sv | 39 +++
 rtl/transpose_buf.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/transpose_pkg.sv
// rtl/transpose_pkg.sv - shared constants and types for the ping-pong transpose buffer
package transpose_pkg;

   localparam int TP_DATA_W = 12;
   localparam int TP_N      = 8;

   typedef enum logic {
      BANK0 = 1'b0,
      BANK1 = 1'b1
   } bank_sel_t;

   typedef enum logic {
      TRANSPOSE = 1'b0,
      PASS      = 1'b1
   } rd_mode_t;

   function automatic bank_sel_t other_bank(input bank_sel_t b);
      return (b == BANK0) ? BANK1 : BANK0;
   endfunction

endpackage

// File: rtl/tbuf_bank.sv
// rtl/tbuf_bank.sv - one N*N sample bank, row/col write port and registered row/col read port
module tbuf_bank #(
   parameter int  DATA_W = 12,
   parameter int  N      = 8,
   localparam int AW     = $clog2(N)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [AW-1:0]     wrow_i,
   input  logic [AW-1:0]     wcol_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     rrow_i,
   input  logic [AW-1:0]     rcol_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [N*N];
   logic [DATA_W-1:0] rdata_q;

   // Storage is deliberately left without reset so it maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[{wrow_i, wcol_i}] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[{rrow_i, rcol_i}];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/transpose_buf.sv
// rtl/transpose_buf.sv - ping-pong N x N transpose / pass-through buffer with valid/ready streams
// Optional out_last marker on the final element of each block: define TRANSPOSE_BUF_LAST_EN.
module transpose_buf
   import transpose_pkg::*;
#(
   parameter int  DATA_W = TP_DATA_W,
   parameter int  N      = TP_N,
   localparam int AW     = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        blocks_held
`ifdef TRANSPOSE_BUF_LAST_EN
   ,
   output logic              out_last
`endif
);

   localparam logic [AW-1:0] LAST = AW'(N - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   bank_sel_t         wbank_q, wbank_d;
   bank_sel_t         rbank_q, rbank_d;
   bank_sel_t         out_sel_q, out_sel_d;
   logic [1:0]        full_q, full_d;
   rd_mode_t          bank_mode_q [2];
   rd_mode_t          bank_mode_d [2];
   logic [AW-1:0]     wr_q, wr_d, wc_q, wc_d;
   logic [AW-1:0]     ra_q, ra_d, rb_q, rb_d;
   logic              out_valid_q, out_valid_d;
`ifdef TRANSPOSE_BUF_LAST_EN
   logic              out_last_q, out_last_d;
`endif

   logic              wr_fire;
   logic              rd_issue;
   logic              rd_last;
   logic              wr_last;
   logic [AW-1:0]     rrow, rcol;
   logic [DATA_W-1:0] rdata0, rdata1;

   assign in_ready = !full_q[wbank_q];
   assign wr_fire  = in_valid && in_ready;
   assign wr_last  = (wr_q == LAST) && (wc_q == LAST);
   assign rd_issue = full_q[rbank_q] && (!out_valid_q || out_ready);
   assign rd_last  = (ra_q == LAST) && (rb_q == LAST);

   // b is the fast index: transpose walks down a column, pass-through along a row.
   always_comb begin
      if (bank_mode_q[rbank_q] == PASS) begin
         rrow = ra_q;
         rcol = rb_q;
      end else begin
         rrow = rb_q;
         rcol = ra_q;
      end
   end

   always_comb begin
      wbank_d        = wbank_q;
      rbank_d        = rbank_q;
      out_sel_d      = out_sel_q;
      full_d         = full_q;
      bank_mode_d[0] = bank_mode_q[0];
      bank_mode_d[1] = bank_mode_q[1];
      wr_d           = wr_q;
      wc_d           = wc_q;
      ra_d           = ra_q;
      rb_d           = rb_q;
      out_valid_d    = out_valid_q;
`ifdef TRANSPOSE_BUF_LAST_EN
      out_last_d     = out_last_q;
`endif

      if (wr_fire) begin
         if ((wr_q == '0) && (wc_q == '0)) begin
            bank_mode_d[wbank_q] = rd_mode_t'(mode);
         end
         if (wr_last) begin
            wr_d            = '0;
            wc_d            = '0;
            full_d[wbank_q] = 1'b1;
            wbank_d         = other_bank(wbank_q);
         end else if (wc_q == LAST) begin
            wc_d = '0;
            wr_d = wr_q + ONE;
         end else begin
            wc_d = wc_q + ONE;
         end
      end

      // The read bank is full here, so it can never be the bank just written above.
      if (rd_issue) begin
         out_valid_d = 1'b1;
         out_sel_d   = rbank_q;
`ifdef TRANSPOSE_BUF_LAST_EN
         out_last_d  = rd_last;
`endif
         if (rd_last) begin
            ra_d            = '0;
            rb_d            = '0;
            full_d[rbank_q] = 1'b0;
            rbank_d         = other_bank(rbank_q);
         end else if (rb_q == LAST) begin
            rb_d = '0;
            ra_d = ra_q + ONE;
         end else begin
            rb_d = rb_q + ONE;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
`ifdef TRANSPOSE_BUF_LAST_EN
         out_last_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbank_q        <= BANK0;
         rbank_q        <= BANK0;
         out_sel_q      <= BANK0;
         full_q         <= '0;
         bank_mode_q[0] <= TRANSPOSE;
         bank_mode_q[1] <= TRANSPOSE;
         wr_q           <= '0;
         wc_q           <= '0;
         ra_q           <= '0;
         rb_q           <= '0;
         out_valid_q    <= 1'b0;
`ifdef TRANSPOSE_BUF_LAST_EN
         out_last_q     <= 1'b0;
`endif
      end else begin
         wbank_q        <= wbank_d;
         rbank_q        <= rbank_d;
         out_sel_q      <= out_sel_d;
         full_q         <= full_d;
         bank_mode_q[0] <= bank_mode_d[0];
         bank_mode_q[1] <= bank_mode_d[1];
         wr_q           <= wr_d;
         wc_q           <= wc_d;
         ra_q           <= ra_d;
         rb_q           <= rb_d;
         out_valid_q    <= out_valid_d;
`ifdef TRANSPOSE_BUF_LAST_EN
         out_last_q     <= out_last_d;
`endif
      end
   end

   tbuf_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (wr_fire && (wbank_q == BANK0)),
      .wrow_i  (wr_q),
      .wcol_i  (wc_q),
      .wdata_i (in_data),
      .re_i    (rd_issue && (rbank_q == BANK0)),
      .rrow_i  (rrow),
      .rcol_i  (rcol),
      .rdata_o (rdata0)
   );

   tbuf_bank #(.DATA_W(DATA_W), .N(N)) u_bank1 (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (wr_fire && (wbank_q == BANK1)),
      .wrow_i  (wr_q),
      .wcol_i  (wc_q),
      .wdata_i (in_data),
      .re_i    (rd_issue && (rbank_q == BANK1)),
      .rrow_i  (rrow),
      .rcol_i  (rcol),
      .rdata_o (rdata1)
   );

   // Each bank holds its last read value, so the stalled output stays stable.
   assign out_data    = (out_sel_q == BANK1) ? rdata1 : rdata0;
   assign out_valid   = out_valid_q;
   assign blocks_held = {1'b0, full_q[0]} + {1'b0, full_q[1]};
`ifdef TRANSPOSE_BUF_LAST_EN
   assign out_last    = out_last_q;
`endif

endmodule
